// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and helpers for the stopwatch controller slice.
//   sw_state_e  : controller FSM state, encoding visible on the state port
//   speed_t     : speed level, 0 (slowest) .. MAX_SPEED (fastest)
//   cmd_e       : the single button command acted on in a given cycle
//   BTN_*       : bit positions of the buttons inside the packed button vector
//   pick_cmd    : fixed-priority selection among the command buttons
//   next_speed  : saturating speed up/down step
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    typedef logic [1:0] speed_t;

    localparam speed_t MAX_SPEED = 2'd3;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_RESET   = 3'd1,
        CMD_START   = 3'd2,
        CMD_REVERSE = 3'd3,
        CMD_ADD     = 3'd4,
        CMD_SUB     = 3'd5
    } cmd_e;

    // Button positions in the packed vector built by the top level.
    localparam int BTN_RESET   = 0;
    localparam int BTN_START   = 1;
    localparam int BTN_REVERSE = 2;
    localparam int BTN_ADD     = 3;
    localparam int BTN_SUB     = 4;
    localparam int BTN_UP      = 5;
    localparam int BTN_DOWN    = 6;
    localparam int NUM_BTNS    = 7;

    // Only one command per cycle; lower-priority presses are simply dropped.
    function automatic cmd_e pick_cmd(input logic rst_p,
                                      input logic start_p,
                                      input logic rev_p,
                                      input logic add_p,
                                      input logic sub_p);
        cmd_e c;
        if (rst_p)        c = CMD_RESET;
        else if (start_p) c = CMD_START;
        else if (rev_p)   c = CMD_REVERSE;
        else if (add_p)   c = CMD_ADD;
        else if (sub_p)   c = CMD_SUB;
        else              c = CMD_NONE;
        return c;
    endfunction

    // Up and down in the same cycle cancel; both ends saturate.
    function automatic speed_t next_speed(input speed_t cur,
                                          input logic   up,
                                          input logic   down);
        speed_t s;
        s = cur;
        if (up && !down && cur != MAX_SPEED) s = cur + 2'd1;
        if (down && !up && cur != 2'd0)      s = cur - 2'd1;
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a single-cycle count-enable pulse for the stopwatch.
// The period is TICK_DIV >> speed_level cycles.
//
// All inputs are the controller's *next-cycle* values (what its registers
// are about to become), so tick_en lines up with the registered state:
// a tick can only be visible in a cycle whose state is RUN, and the cycle
// in which DONE is entered never carries a tick.
//
// Ports
//   clk         : system clock
//   RESET       : asynchronous active-high reset
//   run         : count this cycle (controller enters/stays in RUN)
//   clear       : restart the period (sw_clear pulse)
//   speed_level : speed for the coming cycle; a change restarts the period
//   tick_en     : registered count-enable pulse
// ---------------------------------------------------------------------------
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       run,
    input  logic       clear,
    input  logic [1:0] speed_level,
    output logic       tick_en
);

    // Wide enough to hold TICK_DIV-1, the largest terminal count.
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] term_cnt;
    speed_t        spd_q;

    assign term_cnt = CW'((TICK_DIV >> speed_level) - 1);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cnt     <= '0;
            tick_en <= 1'b0;
            spd_q   <= '0;
        end else begin
            spd_q <= speed_level;
            if (clear || (speed_level != spd_q)) begin
                cnt     <= '0;
                tick_en <= 1'b0;
            end else if (run) begin
                if (cnt == term_cnt) begin
                    cnt     <= '0;
                    tick_en <= 1'b1;
                end else begin
                    cnt     <= cnt + CW'(1);
                    tick_en <= 1'b0;
                end
            end else begin
                // PAUSE/IDLE/DONE: hold the partial count for a later resume.
                tick_en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// ---------------------------------------------------------------------------
// stopwatch_controller
// Button-driven control FSM for a stopwatch: start/pause, count direction,
// add/subtract/clear load pulses, speed selection and the count-enable tick.
//
// Ports
//   clk                      : system clock, rising edge
//   RESET                    : asynchronous active-high reset
//   btn_start .. btn_speed_down : debounced button levels
//   done_in                  : limit reached, from the stopwatch comparator
//   START                    : run enable, high exactly while state == RUN
//   REVERSE                  : count direction, 1 = down
//   sw_clear, ADD, SUBTRACT  : single-cycle load pulses
//   tick_en                  : single-cycle count enable (RUN only)
//   speed_level              : current speed 0..3
//   state                    : FSM state (IDLE=0 RUN=1 PAUSE=2 DONE=3)
//
// Every output is a register; a press sampled on one clock edge is answered
// by the outputs updated on that same edge (one cycle after the press).
// ---------------------------------------------------------------------------
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       btn_start,
    input  logic       btn_reset,
    input  logic       btn_reverse,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       btn_speed_up,
    input  logic       btn_speed_down,
    input  logic       done_in,
    output logic       START,
    output logic       REVERSE,
    output logic       sw_clear,
    output logic       ADD,
    output logic       SUBTRACT,
    output logic       tick_en,
    output logic [1:0] speed_level,
    output logic [1:0] state
);

    logic [NUM_BTNS-1:0] btn_now;
    logic [NUM_BTNS-1:0] btn_q;
    logic [NUM_BTNS-1:0] press;

    sw_state_e st, st_d;
    cmd_e      cmd;
    logic      rev_d, clr_d, add_d, sub_d;
    speed_t    spd_d;

    assign btn_now = {btn_speed_down, btn_speed_up, btn_sub, btn_add,
                      btn_reverse, btn_start, btn_reset};

    // Rising edges only; btn_q resets high so a button held through reset
    // release is not seen as a press.
    assign press = btn_now & ~btn_q;

    assign cmd = pick_cmd(press[BTN_RESET], press[BTN_START], press[BTN_REVERSE],
                          press[BTN_ADD], press[BTN_SUB]);

    assign state = st;

    // Next-value decode. Kept separate from the register block so the
    // prescaler can be fed the same next values the outputs are about to take.
    always_comb begin
        st_d  = st;
        rev_d = REVERSE;
        clr_d = 1'b0;
        add_d = 1'b0;
        sub_d = 1'b0;
        spd_d = next_speed(speed_level, press[BTN_UP], press[BTN_DOWN]);

        unique case (st)
            ST_IDLE, ST_PAUSE: begin
                unique case (cmd)
                    CMD_RESET: begin
                        clr_d = 1'b1;
                        st_d  = ST_IDLE;
                    end
                    // From PAUSE a start only resumes while the limit is clear.
                    CMD_START:   if (st == ST_IDLE || !done_in) st_d = ST_RUN;
                    CMD_REVERSE: rev_d = ~REVERSE;
                    CMD_ADD:     add_d = 1'b1;
                    CMD_SUB:     sub_d = 1'b1;
                    default: ;
                endcase
            end
            ST_RUN: begin
                // Limit reached outranks every button, reset included.
                if (done_in) begin
                    st_d = ST_DONE;
                end else if (cmd == CMD_RESET) begin
                    clr_d = 1'b1;
                    st_d  = ST_IDLE;
                end else if (cmd == CMD_START) begin
                    st_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (cmd == CMD_RESET) begin
                    clr_d = 1'b1;
                    st_d  = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            st          <= ST_IDLE;
            START       <= 1'b0;
            REVERSE     <= 1'b0;
            sw_clear    <= 1'b0;
            ADD         <= 1'b0;
            SUBTRACT    <= 1'b0;
            speed_level <= '0;
            btn_q       <= '1;
        end else begin
            st          <= st_d;
            START       <= (st_d == ST_RUN);
            REVERSE     <= rev_d;
            sw_clear    <= clr_d;
            ADD         <= add_d;
            SUBTRACT    <= sub_d;
            speed_level <= spd_d;
            btn_q       <= btn_now;
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk         (clk),
        .RESET       (RESET),
        .run         (st_d == ST_RUN),
        .clear       (clr_d),
        .speed_level (spd_d),
        .tick_en     (tick_en)
    );

endmodule

// File: tb/tb_stopwatch_controller.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_controller
// Directed scenarios with literal expectations, followed by a long random
// run; a behavioural model is compared against the DUT on every cycle.
// ---------------------------------------------------------------------------
module tb_stopwatch_controller;

    localparam int TICK_DIV = 16;

    localparam int I_RST = 0, I_START = 1, I_REV = 2, I_ADD = 3,
                   I_SUB = 4, I_UP = 5, I_DN = 6;

    logic       clk;
    logic       RESET;
    logic [6:0] bvec;
    logic       done_in;
    logic       START, REVERSE, sw_clear, ADD, SUBTRACT, tick_en;
    logic [1:0] speed_level, state;

    stopwatch_controller #(.TICK_DIV(TICK_DIV)) dut (
        .clk            (clk),
        .RESET          (RESET),
        .btn_start      (bvec[I_START]),
        .btn_reset      (bvec[I_RST]),
        .btn_reverse    (bvec[I_REV]),
        .btn_add        (bvec[I_ADD]),
        .btn_sub        (bvec[I_SUB]),
        .btn_speed_up   (bvec[I_UP]),
        .btn_speed_down (bvec[I_DN]),
        .done_in        (done_in),
        .START          (START),
        .REVERSE        (REVERSE),
        .sw_clear       (sw_clear),
        .ADD            (ADD),
        .SUBTRACT       (SUBTRACT),
        .tick_en        (tick_en),
        .speed_level    (speed_level),
        .state          (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States as plain numbers: 0 idle, 1 run, 2 pause, 3 done.
    int       m_state = 0;
    int       m_speed = 0;
    int       m_cnt   = 0;   // RUN cycles counted in the current period
    bit       m_rev = 0, m_clear = 0, m_add = 0, m_sub = 0, m_tick = 0;
    bit [6:0] m_prev = '1;
    bit [6:0] m_p;
    int       m_first, m_old_spd;

    always @(posedge clk or posedge RESET) begin
        if (RESET) begin
            m_state = 0; m_speed = 0; m_cnt = 0;
            m_rev = 0; m_clear = 0; m_add = 0; m_sub = 0; m_tick = 0;
            m_prev = '1;
        end else begin
            m_p    = bvec & ~m_prev;
            m_prev = bvec;
            m_clear = 0; m_add = 0; m_sub = 0;
            m_old_spd = m_speed;
            m_first = -1;
            for (int i = 4; i >= 0; i--) if (m_p[i]) m_first = i;

            if (m_state == 1 && done_in) m_state = 3;
            else if (m_first == I_RST) begin m_clear = 1; m_state = 0; end
            else if (m_first == I_START) begin
                if (m_state == 0) m_state = 1;
                else if (m_state == 1) m_state = 2;
                else if (m_state == 2 && !done_in) m_state = 1;
            end else if (m_state == 0 || m_state == 2) begin
                if (m_first == I_REV) m_rev = !m_rev;
                if (m_first == I_ADD) m_add = 1;
                if (m_first == I_SUB) m_sub = 1;
            end

            if (m_p[I_UP] && !m_p[I_DN] && m_speed < 3) m_speed++;
            if (m_p[I_DN] && !m_p[I_UP] && m_speed > 0) m_speed--;

            if (m_clear || m_speed != m_old_spd) begin
                m_cnt = 0; m_tick = 0;
            end else if (m_state == 1) begin
                m_cnt++;
                m_tick = (m_cnt == (TICK_DIV >> m_speed));
                if (m_tick) m_cnt = 0;
            end else m_tick = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_state",    32'(state),       32'(m_state));
            chk("m_START",    32'(START),       32'(m_state == 1));
            chk("m_REVERSE",  32'(REVERSE),     32'(m_rev));
            chk("m_sw_clear", 32'(sw_clear),    32'(m_clear));
            chk("m_ADD",      32'(ADD),         32'(m_add));
            chk("m_SUBTRACT", 32'(SUBTRACT),    32'(m_sub));
            chk("m_tick_en",  32'(tick_en),     32'(m_tick));
            chk("m_speed",    32'(speed_level), 32'(m_speed));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise a button for one sampled edge; returns just after that edge.
    task automatic press(input int i);
        bvec[i] = 1'b1;
        cyc(1);
        bvec[i] = 1'b0;
    endtask

    int nt, na;

    initial begin
        RESET = 1'b1; bvec = '0; done_in = 1'b0;
        @(posedge clk);
        chk_on = 1;
        cyc(1);
        chk("rst_state", 32'(state), 0);
        chk("rst_START", 32'(START), 0);
        chk("rst_speed", 32'(speed_level), 0);
        chk("rst_tick",  32'(tick_en), 0);
        RESET = 1'b0;
        cyc(1);

        // start, 16-cycle ticks, pause holds count, resume finishes period
        press(I_START);
        chk("start_state", 32'(state), 1);
        chk("start_START", 32'(START), 1);
        cyc(14); chk("run_c15_tick", 32'(tick_en), 0);
        cyc(1);  chk("run_c16_tick", 32'(tick_en), 1);
        cyc(5);
        press(I_START);
        chk("pause_state", 32'(state), 2);
        chk("pause_START", 32'(START), 0);
        nt = 0;
        for (int k = 0; k < 20; k++) begin cyc(1); nt += int'(tick_en); end
        chk("pause_ticks", 32'(nt), 0);
        press(I_START);
        chk("resume_state", 32'(state), 1);
        cyc(9); chk("resume_c10_tick", 32'(tick_en), 0);
        cyc(1); chk("resume_c11_tick", 32'(tick_en), 1);

        // speed up: period 4, then saturating at 3 with period 2
        press(I_UP); cyc(1);
        press(I_UP);
        chk("spd2", 32'(speed_level), 2);
        chk("spd2_tick", 32'(tick_en), 0);
        cyc(3); chk("spd2_c3", 32'(tick_en), 0);
        cyc(1); chk("spd2_c4", 32'(tick_en), 1);
        cyc(3); chk("spd2_c7", 32'(tick_en), 0);
        cyc(1); chk("spd2_c8", 32'(tick_en), 1);
        press(I_UP); cyc(1);
        press(I_UP);
        chk("spd3_sat", 32'(speed_level), 3);
        chk("spd3_tick_a", 32'(tick_en), 1);
        cyc(1); chk("spd3_tick_b", 32'(tick_en), 0);
        cyc(1); chk("spd3_tick_c", 32'(tick_en), 1);
        press(I_DN); cyc(1); press(I_DN); cyc(1); press(I_DN);
        chk("spd0", 32'(speed_level), 0);
        cyc(1);

        // done_in beats start; DONE only answers reset
        done_in = 1'b1; bvec[I_START] = 1'b1;
        cyc(1);
        chk("done_state", 32'(state), 3);
        chk("done_START", 32'(START), 0);
        chk("done_tick",  32'(tick_en), 0);
        bvec[I_START] = 1'b0; done_in = 1'b0;
        cyc(1);
        press(I_START);
        chk("done_ign_start", 32'(state), 3);
        cyc(1);
        press(I_RST);
        chk("done_rst_clear", 32'(sw_clear), 1);
        chk("done_rst_state", 32'(state), 0);
        cyc(1);
        chk("clear_one_cyc", 32'(sw_clear), 0);

        // reset + add + reverse together in IDLE: only the clear happens
        bvec[I_RST] = 1'b1; bvec[I_ADD] = 1'b1; bvec[I_REV] = 1'b1;
        cyc(1);
        chk("prio_clear", 32'(sw_clear), 1);
        chk("prio_rev",   32'(REVERSE), 0);
        chk("prio_add",   32'(ADD), 0);
        bvec = '0;
        cyc(1);

        // PAUSE reverse, held add gives one pulse, sub ignored in RUN
        press(I_START); cyc(1);
        press(I_START);
        chk("p_state", 32'(state), 2);
        cyc(1);
        press(I_REV);
        chk("p_rev", 32'(REVERSE), 1);
        cyc(1);
        bvec[I_ADD] = 1'b1; na = 0;
        for (int k = 0; k < 10; k++) begin cyc(1); na += int'(ADD); end
        bvec[I_ADD] = 1'b0;
        chk("add_held_pulses", 32'(na), 1);
        press(I_START); cyc(1);
        press(I_SUB);
        chk("run_sub_ign", 32'(SUBTRACT), 0);
        chk("run_sub_state", 32'(state), 1);
        cyc(1);
        press(I_RST);
        chk("run_rst_state", 32'(state), 0);
        chk("run_rst_rev",   32'(REVERSE), 1);
        cyc(1);

        // start held through reset release
        bvec[I_START] = 1'b1;
        RESET = 1'b1;
        cyc(2);
        chk("hold_rst_rev", 32'(REVERSE), 0);
        RESET = 1'b0;
        cyc(3);
        chk("hold_state", 32'(state), 0);
        chk("hold_START", 32'(START), 0);
        bvec[I_START] = 1'b0;
        cyc(1);
        press(I_START);
        chk("hold_repress", 32'(state), 1);
        cyc(1);

        // random run, checked against the model every cycle
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 9)  == 0) bvec[I_START] = ~bvec[I_START];
            if ($urandom_range(0, 39) == 0) bvec[I_RST]   = ~bvec[I_RST];
            if ($urandom_range(0, 11) == 0) bvec[I_REV]   = ~bvec[I_REV];
            if ($urandom_range(0, 11) == 0) bvec[I_ADD]   = ~bvec[I_ADD];
            if ($urandom_range(0, 11) == 0) bvec[I_SUB]   = ~bvec[I_SUB];
            if ($urandom_range(0, 19) == 0) bvec[I_UP]    = ~bvec[I_UP];
            if ($urandom_range(0, 19) == 0) bvec[I_DN]    = ~bvec[I_DN];
            done_in = ($urandom_range(0, 29) == 0);
            if (!RESET && $urandom_range(0, 399) == 0) RESET = 1'b1;
            else if (RESET && $urandom_range(0, 1) == 0) RESET = 1'b0;
            cyc(1);
        end
        RESET = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
